// File: rtl/reg_share_pkg.sv
// reg_share_pkg: shared types and width helpers for the register-sharing arbiter.
//   state_t : arbiter FSM state (IDLE = open arbitration, OWNED = locked burst)
//   idx_w   : bit width needed to index n requesters (at least 1)
package reg_share_pkg;

    typedef enum logic {IDLE, OWNED} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req   [N-1:0]  : request vector
//   ptr   [IW-1:0] : highest-priority index (must be < N)
//   grant [N-1:0]  : one-hot grant of the first request at or after ptr (mod N)
//   idx   [IW-1:0] : index of the granted request
//   any            : at least one request present
module rr_pick
    import reg_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the lowest priority to the highest so the last hit,
    // i.e. the one closest to ptr, wins. Manual wrap supports non-power-of-two N.
    always_comb begin
        int j;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) idx = IW'(j);
        end
        any   = |req;
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin write port for one shared register, with bounded lock bursts.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_lock : per-requester write request and keep-ownership request
//   req_data           : requester i data at [i*WIDTH +: WIDTH]
//   req_ready          : one-hot grant (transfer = valid & ready)
//   q, q_upd           : register contents and one-cycle new-data strobe
//   owner              : last writer or current lock holder
//   busy               : a lock is held
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           q,
    output logic                       q_upd,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int IW = idx_w(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx, owner_nx, pick_idx, sel;
    logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
    logic [N_REQ-1:0] pick_grant;
    logic            pick_any, xfer;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel  = (state == IDLE) ? pick_idx : owner;
    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            q     <= '0;
            q_upd <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            owner <= owner_nx;
            cnt   <= cnt_nx;
            q_upd <= xfer;
            if (xfer) q <= req_data[sel*WIDTH +: WIDTH];
        end
    end

    // In OWNED an unlocked owner releases whether or not it transfers,
    // so the two lock-drop release conditions collapse into !req_lock[owner].
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        cnt_nx   = cnt;
        cnt_inc  = cnt + 1'b1;
        if (state == IDLE) begin
            if (pick_any) begin
                owner_nx = pick_idx;
                if (req_lock[pick_idx] && MAX_BURST > 1) begin
                    state_nx = OWNED;
                    cnt_nx   = CW'(1);
                end else begin
                    ptr_nx = inc(pick_idx);
                end
            end
        end else if (!req_lock[owner] || cnt_inc == CW'(MAX_BURST)) begin
            state_nx = IDLE;
            ptr_nx   = inc(owner);
            cnt_nx   = '0;
        end else begin
            cnt_nx = cnt_inc;
        end
    end

    always_comb begin
        req_ready = rst ? '0 : (state == IDLE) ? pick_grant : (req_valid & (N_REQ'(1) << owner));
        busy      = (state == OWNED);
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed self-checking bench for reg_share_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_reg_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_lock, req_ready;
    logic [31:0] req_data;
    logic [7:0]  q;
    logic        q_upd, busy;
    logic [1:0]  owner;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q         (q),
        .q_upd     (q_upd),
        .owner     (owner),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_lock = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'hF;
        req_lock = '0;
        req_data = '0;
        // 1. reset with all requests pending
        #1;
        chk("rst_ready0", req_ready, 4'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready", req_ready, 4'h0);
            chk("rst_q", q, 8'h00);
            chk("rst_qupd", q_upd, 1'b0);
            chk("rst_owner", owner, 2'd0);
            chk("rst_busy", busy, 1'b0);
        end
        rst = 1'b0;
        req_valid = '0;
        // 2. single write from requester 2
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'hA5;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single_q", q, 8'hA5);
        chk("single_qupd", q_upd, 1'b1);
        chk("single_owner", owner, 2'd2);
        tick();
        chk("single_qupd_low", q_upd, 1'b0);
        chk("single_q_hold", q, 8'hA5);
        // 3. round robin from a fresh pointer
        do_reset();
        req_valid = 4'hF;
        req_data = 32'h13121110;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_ready", req_ready, 4'b0001 << (i % 4));
            tick();
            chk("rr_q", q, 8'h10 + (i % 4));
            chk("rr_qupd", q_upd, 1'b1);
        end
        req_valid = '0;
        // 4. burst cap: ptr is now 1, req1 locks, req3 waits
        req_valid = 4'b1010;
        req_lock = 4'b0010;
        req_data = 32'h23002100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cap_ready1", req_ready, 4'b0010);
            chk("cap_busy", busy, i > 0);
            tick();
        end
        chk("cap_q", q, 8'h21);
        chk("cap_release", busy, 1'b0);
        chk("cap_ready3", req_ready, 4'b1000);
        tick();
        chk("cap_q3", q, 8'h23);
        chk("cap_owner3", owner, 2'd3);
        chk("cap_again1", req_ready, 4'b0010);
        tick();
        chk("cap_busy_again", busy, 1'b1);
        req_valid = '0;
        req_lock = '0;
        tick();
        chk("cap_unlock", busy, 1'b0);
        // 5. locked hold blocks another requester until the burst ends
        do_reset();
        req_valid = 4'b0001;
        req_lock = 4'b0001;
        req_data = 32'h00520030;
        #1;
        chk("hold_ready0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_blocked", req_ready, 4'b0000);
            chk("hold_busy", busy, 1'b1);
            chk("hold_q", q, 8'h30);
            tick();
        end
        chk("hold_free", busy, 1'b0);
        chk("hold_ready2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        req_lock = '0;
        #1;
        chk("hold_q2", q, 8'h52);
        chk("hold_qupd2", q_upd, 1'b1);
        chk("hold_owner2", owner, 2'd2);
        // 6. reset in the OWNED cycle where cnt=2; ptr is 3 here, only req0 valid
        req_valid = 4'b0001;
        req_lock = 4'b0001;
        req_data = 32'h00000060;
        #1;
        chk("mid_ready0", req_ready, 4'b0001);
        tick();
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("mid_busy_pre", busy, 1'b1);
        chk("mid_rst_ready", req_ready, 4'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_q", q, 8'h00);
        chk("mid_qupd", q_upd, 1'b0);
        chk("mid_owner", owner, 2'd0);
        chk("mid_ready", req_ready, 4'b0001);
        tick();
        chk("mid_q_after", q, 8'h60);
        req_valid = '0;
        req_lock = '0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Shares a single WIDTH-bit register (a bank of D flip-flops) among N_REQ requesters using round-robin arbitration.
- A requester can lock ownership for a bounded burst of writes.
- It sits in front of the register bank as its sole write port.
- It presents the registered value, an update strobe and the current owner to downstream logic.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, data/register width in bits
MAX_BURST, 4, maximum cycles a locking requester may hold ownership (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester write request
req_lock  input  N_REQ  per-requester request to retain ownership after this write
req_data  input  N_REQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  N_REQ  grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
q  output  WIDTH  shared register contents
q_upd  output  1  one-cycle pulse, high in the cycle q holds newly written data
owner  output  $clog2(N_REQ)  index of the last requester that wrote, or of the current lock holder
busy  output  1  high while a requester holds a lock

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, q=0, q_upd=0, owner=0, rr pointer ptr=0, burst counter cnt=0. While rst=1, req_ready=0.
- req_ready is combinational from state, ptr, owner, req_valid. At most one bit of req_ready is high per cycle.
- Accepted data appears on q one cycle after the transfer cycle, with q_upd=1 in that cycle. q holds its value when there is no transfer.
- IDLE state:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ. req_ready[winner]=1.
  - On transfer: q<=data, owner<=winner.
  - If req_lock[winner]=1 and MAX_BURST>1: go to OWNED with cnt=1.
  - Otherwise: stay in IDLE, ptr<=winner+1 (mod N_REQ).
  - No valid request: nothing changes.
- OWNED state (busy=1):
  - Only owner may be granted: req_ready[owner]=req_valid[owner]. All other bits are 0.
  - Every OWNED cycle increments cnt, whether or not a transfer occurs.
  - Release to IDLE, with ptr<=owner+1 and cnt<=0, when any of these holds:
    - a transfer occurs with req_lock[owner]=0;
    - req_valid[owner]=0 and req_lock[owner]=0;
    - cnt reaches MAX_BURST at the end of this cycle.
  - A transfer in the release cycle is still performed.
  - req_valid[owner]=0 with req_lock[owner]=1 is a hold cycle: no transfer, ownership is kept, and the cycle counts toward cnt.
- Burst bound: one requester never owns more than MAX_BURST consecutive cycles. This guarantees no starvation.
- Simultaneous events: rst has priority over everything. Requests arriving during OWNED wait and are arbitrated in the first IDLE cycle.
- Reset mid-operation: on the next edge, all state returns to reset values. A transfer presented in the rst cycle is dropped.
- Width rules: ptr and owner are $clog2(N_REQ) bits and wrap modulo N_REQ, which need not be a power of two. cnt is $clog2(MAX_BURST+1) bits.

Decomposition:
- Package reg_share_pkg: state enum {IDLE, OWNED} and index-width helper constants.
- Sub-module rr_pick: combinational rotating-priority encoder (inputs req vector and ptr; outputs one-hot grant, index and any-valid). It is reused by future arbiters.

Test Plan (N_REQ=4, WIDTH=8, MAX_BURST=4):
1. Reset: hold rst=1 for 2 cycles with req_valid=4'hF -> req_ready=0, q=8'h00, q_upd=0, owner=0, busy=0 throughout.
2. Single write: req_valid[2]=1, data 8'hA5 for one cycle -> req_ready[2]=1 same cycle; next cycle q=8'hA5, q_upd=1, owner=2; following cycle q_upd=0 and q stays 8'hA5.
3. Round-robin: all valid, no lock, data_i=8'h10+i, for 5 cycles -> grants 0,1,2,3,0; q sequence 8'h10,8'h11,8'h12,8'h13,8'h10.
4. Burst cap: req1 valid and locked continuously, req3 valid -> req1 granted 4 consecutive cycles, busy=1; then req3 granted next (ptr=2); then req1 again.
5. Locked hold: req0 writes with lock, then valid=0, lock=1 while req2 valid -> req_ready[2]=0 until the 4th OWNED cycle ends; then req2 is granted and q=req2 data one cycle later.
6. Reset mid-burst: rst=1 for one cycle during OWNED with cnt=2 -> next cycle busy=0, q=0, owner=0, and arbitration restarts from requester 0.
